// File: rtl/boa_stage_if.sv
// Boa32 instruction fetch stage.
// Owns the fetch PC, issues word reads on the instruction bus and fills the
// IF/ID register. A one-entry skid buffer catches the single response that can
// still arrive while decode is stalled, so no instruction is lost or repeated.
module boa_stage_if #(
  parameter logic [31:0] entrypoint = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // IF/ID register
  output logic        q_valid,
  output logic [31:2] q_pc,
  output logic [31:0] q_insn,
  output logic        q_trap,
  output logic [3:0]  q_cause,
  // Redirect sources
  input  logic        id_branch_predict,
  input  logic [31:2] id_branch_target,
  input  logic        fw_branch_correct,
  input  logic [31:2] fw_branch_target,
  input  logic        fw_stall_if,
  // Instruction bus
  output logic        pbus_re,
  output logic [31:2] pbus_addr,
  input  logic        pbus_ready,
  input  logic [31:0] pbus_rdata,
  input  logic        pbus_err
);

  localparam logic [3:0] CAUSE_FETCH_FAULT = 4'd1;

  // Fetch bookkeeping
  logic [31:2] r_pc;
  logic        r_pend;
  logic [31:2] r_pendPc;
  logic        r_discard;
  logic        r_halted;

  // Skid buffer (valid is implied by the absence of a trap)
  logic        r_skidFull;
  logic [31:2] r_skidPc;
  logic [31:0] r_skidInsn;
  logic        r_skidTrap;

  logic        w_redirect;
  logic [31:2] w_redirTarget;
  logic        w_accept;
  logic        w_resp;
  logic        w_fault;

  // A later-stage correction always wins; a decode prediction only counts
  // when decode is actually advancing.
  assign w_redirect    = fw_branch_correct || (id_branch_predict && !fw_stall_if);
  assign w_redirTarget = fw_branch_correct ? fw_branch_target : id_branch_target;

  // While stalled, only issue if the response is guaranteed a free skid slot.
  assign pbus_re   = !rst && !r_halted && (!fw_stall_if || (!r_pend && !r_skidFull));
  assign pbus_addr = r_pc;
  assign w_accept  = pbus_re && pbus_ready;

  // A response is usable only if it was not flagged stale and no redirect is
  // throwing away the current instruction stream this cycle.
  assign w_resp  = r_pend && !r_discard && !w_redirect;
  assign w_fault = w_resp && pbus_err;

  // Track the PC, the single outstanding read and the halt-after-fault flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= entrypoint[31:2];
      r_pend    <= 1'b0;
      r_discard <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_pend    <= w_accept;
      r_discard <= w_accept && (w_redirect || w_fault);
      if (w_accept) begin
        r_pendPc <= r_pc;
      end
      if (w_redirect) begin
        r_pc <= w_redirTarget;
      end else if (w_accept) begin
        r_pc <= r_pc + 30'd1;
      end
      if (w_redirect) begin
        r_halted <= 1'b0;
      end else if (w_fault) begin
        r_halted <= 1'b1;
      end
    end
  end

  // Move responses into the IF/ID register, parking one in the skid when
  // decode cannot take it or an older parked entry must go first.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid    <= 1'b0;
      q_trap     <= 1'b0;
      r_skidFull <= 1'b0;
    end else if (w_redirect) begin
      q_valid    <= 1'b0;
      q_trap     <= 1'b0;
      r_skidFull <= 1'b0;
    end else if (!fw_stall_if) begin
      if (r_skidFull) begin
        q_valid    <= !r_skidTrap;
        q_trap     <= r_skidTrap;
        q_cause    <= r_skidTrap ? CAUSE_FETCH_FAULT : 4'd0;
        q_pc       <= r_skidPc;
        q_insn     <= r_skidInsn;
        r_skidFull <= w_resp;
        if (w_resp) begin
          r_skidPc   <= r_pendPc;
          r_skidInsn <= pbus_rdata;
          r_skidTrap <= pbus_err;
        end
      end else if (w_resp) begin
        q_valid <= !pbus_err;
        q_trap  <= pbus_err;
        q_cause <= pbus_err ? CAUSE_FETCH_FAULT : 4'd0;
        q_pc    <= r_pendPc;
        q_insn  <= pbus_rdata;
      end else begin
        q_valid <= 1'b0;
        q_trap  <= 1'b0;
      end
    end else if (w_resp) begin
      r_skidFull <= 1'b1;
      r_skidPc   <= r_pendPc;
      r_skidInsn <= pbus_rdata;
      r_skidTrap <= pbus_err;
    end
  end

endmodule

// File: tb/tb_boa_stage_if.sv
// Directed bench for the Boa32 fetch stage. A small memory model returns the
// word index as the instruction word, one cycle after each accepted read.
module tb_boa_stage_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        q_valid;
  logic [31:2] q_pc;
  logic [31:0] q_insn;
  logic        q_trap;
  logic [3:0]  q_cause;
  logic        id_branch_predict;
  logic [31:2] id_branch_target;
  logic        fw_branch_correct;
  logic [31:2] fw_branch_target;
  logic        fw_stall_if;
  logic        pbus_re;
  logic [31:2] pbus_addr;
  logic        pbus_ready;
  logic [31:0] pbus_rdata;
  logic        pbus_err;

  logic        errEnable;
  logic [31:2] errAddr;

  int checks = 0;
  int errors = 0;

  localparam logic [31:2] A0 = 30'h1000_0000;

  boa_stage_if dut (
    .clk               (clk),
    .rst               (rst),
    .q_valid           (q_valid),
    .q_pc              (q_pc),
    .q_insn            (q_insn),
    .q_trap            (q_trap),
    .q_cause           (q_cause),
    .id_branch_predict (id_branch_predict),
    .id_branch_target  (id_branch_target),
    .fw_branch_correct (fw_branch_correct),
    .fw_branch_target  (fw_branch_target),
    .fw_stall_if       (fw_stall_if),
    .pbus_re           (pbus_re),
    .pbus_addr         (pbus_addr),
    .pbus_ready        (pbus_ready),
    .pbus_rdata        (pbus_rdata),
    .pbus_err          (pbus_err)
  );

  always #5 clk = ~clk;

  // Memory: word i holds i; garbage on cycles without a response.
  always @(posedge clk) begin
    if (pbus_re && pbus_ready) begin
      pbus_rdata <= {2'b00, pbus_addr};
      pbus_err   <= errEnable && (pbus_addr == errAddr);
    end else begin
      pbus_rdata <= 32'hdead_beef;
      pbus_err   <= 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkQ(input string tag, input logic [31:2] pc);
    checkOutput({tag, ".valid"}, {31'd0, q_valid}, 32'd1);
    checkOutput({tag, ".pc"}, {2'b00, q_pc}, {2'b00, pc});
    checkOutput({tag, ".insn"}, q_insn, {2'b00, pc});
  endtask

  task automatic checkEmpty(input string tag);
    checkOutput({tag, ".valid"}, {31'd0, q_valid}, 32'd0);
    checkOutput({tag, ".trap"}, {31'd0, q_trap}, 32'd0);
  endtask

  task automatic applyStimulus(input logic stall, input logic predict,
                               input logic [31:2] idTarget, input logic correct,
                               input logic [31:2] fwTarget);
    fw_stall_if       = stall;
    id_branch_predict = predict;
    id_branch_target  = idTarget;
    fw_branch_correct = correct;
    fw_branch_target  = fwTarget;
  endtask

  // Directed sequence; inputs change and outputs are sampled on falling edges.
  initial begin
    rst        = 1'b1;
    pbus_ready = 1'b1;
    errEnable  = 1'b0;
    errAddr    = A0 + 30'd4;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);

    @(negedge clk);
    @(negedge clk);
    checkEmpty("reset");
    checkOutput("reset.re", {31'd0, pbus_re}, 32'd0);

    rst = 1'b0;
    #1;
    checkOutput("start.re", {31'd0, pbus_re}, 32'd1);
    checkOutput("start.addr", {2'b00, pbus_addr}, {2'b00, A0});

    @(negedge clk);
    checkEmpty("start.cycle2");
    checkOutput("start.addr2", {2'b00, pbus_addr}, {2'b00, A0 + 30'd1});

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkQ("stream", A0 + 30'(i));
    end

    // Decode stalls for three cycles mid-stream
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkQ("stall.hold", A0 + 30'd3);
      checkOutput("stall.re", {31'd0, pbus_re}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    for (int i = 4; i < 7; i++) begin
      @(negedge clk);
      checkQ("stall.resume", A0 + 30'(i));
    end

    // Decode prediction while a fetch is outstanding
    applyStimulus(1'b0, 1'b1, 30'h100, 1'b0, '0);
    @(negedge clk);
    checkEmpty("predict.flush");
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checkEmpty("predict.stale");
    @(negedge clk);
    checkQ("predict.first", 30'h100);
    @(negedge clk);
    checkQ("predict.next", 30'h101);

    // Simultaneous correction and prediction: the correction wins
    applyStimulus(1'b0, 1'b1, 30'h300, 1'b1, 30'h200);
    @(negedge clk);
    checkEmpty("prio.flush");
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checkEmpty("prio.stale");
    @(negedge clk);
    checkQ("prio.first", 30'h200);
    @(negedge clk);
    checkQ("prio.next", 30'h201);

    // PC wraps from the top of the address space to zero
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 30'h3fff_ffff);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    checkQ("wrap.top", 30'h3fff_ffff);
    @(negedge clk);
    checkQ("wrap.zero", 30'h0);

    // Access fault on the fetch of A0+4
    errEnable = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, 1'b1, A0 + 30'd2);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    checkQ("fault.before0", A0 + 30'd2);
    @(negedge clk);
    checkQ("fault.before1", A0 + 30'd3);
    @(negedge clk);
    checkOutput("fault.valid", {31'd0, q_valid}, 32'd0);
    checkOutput("fault.trap", {31'd0, q_trap}, 32'd1);
    checkOutput("fault.cause", {28'd0, q_cause}, 32'd1);
    checkOutput("fault.re0", {31'd0, pbus_re}, 32'd0);
    @(negedge clk);
    checkOutput("fault.re1", {31'd0, pbus_re}, 32'd0);
    checkEmpty("fault.drop");
    @(negedge clk);
    checkOutput("fault.re2", {31'd0, pbus_re}, 32'd0);
    errEnable = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 30'h10);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    checkOutput("fault.resume.re", {31'd0, pbus_re}, 32'd1);
    checkOutput("fault.resume.addr", {2'b00, pbus_addr}, 32'h10);
    @(negedge clk);
    checkEmpty("fault.resume.gap");
    @(negedge clk);
    checkQ("fault.resume.first", 30'h10);
    @(negedge clk);
    checkQ("fault.resume.next", 30'h11);

    // Bus not ready for two cycles
    pbus_ready = 1'b0;
    @(negedge clk);
    checkQ("ready.inflight", 30'h12);
    checkOutput("ready.re0", {31'd0, pbus_re}, 32'd1);
    checkOutput("ready.addr0", {2'b00, pbus_addr}, 32'h13);
    @(negedge clk);
    checkEmpty("ready.bubble0");
    checkOutput("ready.re1", {31'd0, pbus_re}, 32'd1);
    checkOutput("ready.addr1", {2'b00, pbus_addr}, 32'h13);
    pbus_ready = 1'b1;
    @(negedge clk);
    checkEmpty("ready.bubble1");
    @(negedge clk);
    checkQ("ready.resume", 30'h13);

    // Reset while a fetch is outstanding
    rst = 1'b1;
    @(negedge clk);
    checkEmpty("rst2.hold");
    checkOutput("rst2.re", {31'd0, pbus_re}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkEmpty("rst2.noStale");
    @(negedge clk);
    checkQ("rst2.first", A0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
